// File: rtl/calc_pkg.sv
// Shared types and segment constants for the calculator display path.
// Segment order is {g,f,e,d,c,b,a}, active-high.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    SHOW,
    BLANK
  } state_t;

  typedef enum logic [1:0] {
    SYM_BLANK,
    SYM_DIGIT,
    SYM_MINUS,
    SYM_E
  } sym_kind_t;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b0111111, 7'b0000110, 7'b1011011,
    7'b1001111, 7'b1100110, 7'b1101101,
    7'b1111101, 7'b0000111, 7'b1111111,
    7'b1101111
  };

  localparam logic [6:0] SEG_MINUS = 7'b1000000;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/calc_seg7_encode.sv
// Symbol to 7-segment encoder; digits above 9 render blank.
// Shared with any other status display on the board.
module calc_seg7_encode
  import calc_pkg::*;
(
  input  logic [3:0] i_code,
  input  sym_kind_t  i_kind,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    unique case (i_kind)
      SYM_DIGIT: begin
        if (i_code <= 4'd9) o_seg = SEG_DIGIT[i_code];
      end
      SYM_MINUS: o_seg = SEG_MINUS;
      SYM_E:     o_seg = SEG_E;
      default:   o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/calc_result_display.sv
// Signed result -> sequential double-dabble -> symbol-by-symbol playout
// on one 7-segment digit, dp marking the last symbol of the sequence.
module calc_result_display
  import calc_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int NDIG       = 3,
  parameter int DIGIT_HOLD = 6000000,
  parameter int GAP        = 1500000,
  parameter int END_GAP    = 6000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             result_valid,
  input  logic [WIDTH-1:0] result,
  input  logic             error,
  output logic [6:0]       segments,
  output logic             dp,
  output logic             busy
);

  localparam int LGAP = GAP + END_GAP;
  localparam int CMAX = (DIGIT_HOLD > LGAP) ? DIGIT_HOLD : LGAP;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int IW   = $clog2(NDIG + 2);
  localparam int NS   = 1 << IW;
  localparam int BCDW = 4 * NDIG;

  state_t           r_state, w_state_nxt;
  logic             r_err, r_sign;
  logic [WIDTH-1:0] r_mag, w_mag_nxt;
  logic [BCDW-1:0]  r_bcd, w_bcd_adj, w_bcd_nxt;
  logic [BW-1:0]    r_bitcnt;
  logic [CW-1:0]    r_cnt;
  logic [IW-1:0]    r_idx, r_nsym, w_nsym;
  sym_kind_t        r_kind [NS];
  sym_kind_t        w_kind [NS];
  logic [3:0]       r_code [NS];
  logic [3:0]       w_code [NS];
  logic             w_conv_done, w_cnt_zero, w_last;
  logic [6:0]       w_seg;

  assign w_conv_done = (r_state == CONVERT)
                    && (r_bitcnt == BW'(WIDTH - 1));
  assign w_cnt_zero  = (r_cnt == '0);
  assign w_last      = (r_idx == r_nsym - IW'(1));

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int d = 0; d < NDIG; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5)
        w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
    end
    {w_bcd_nxt, w_mag_nxt} = {w_bcd_adj, r_mag} << 1;
  end

  // Symbol list from the post-final-shift BCD, leading zeros dropped.
  always_comb begin
    logic       started;
    logic [3:0] dig;
    started = 1'b0;
    dig     = '0;
    w_nsym  = '0;
    for (int s = 0; s < NS; s++) begin
      w_kind[s] = SYM_BLANK;
      w_code[s] = '0;
    end
    if (r_err) begin
      w_kind[0] = SYM_E;
      w_nsym    = IW'(1);
    end else begin
      if (r_sign) begin
        w_kind[0] = SYM_MINUS;
        w_nsym    = IW'(1);
      end
      for (int d = NDIG - 1; d >= 0; d--) begin
        dig = w_bcd_nxt[4*d +: 4];
        if (started || dig != 4'd0 || d == 0) begin
          w_kind[w_nsym] = SYM_DIGIT;
          w_code[w_nsym] = dig;
          w_nsym  = w_nsym + IW'(1);
          started = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (result_valid) begin
      w_state_nxt = CONVERT;
    end else begin
      unique case (r_state)
        IDLE:    w_state_nxt = IDLE;
        CONVERT: if (w_conv_done) w_state_nxt = SHOW;
        SHOW:    if (w_cnt_zero)  w_state_nxt = BLANK;
        BLANK:   if (w_cnt_zero)  w_state_nxt = SHOW;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err    <= 1'b0;
      r_sign   <= 1'b0;
      r_mag    <= '0;
      r_bcd    <= '0;
      r_bitcnt <= '0;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_nsym   <= '0;
      r_kind   <= '{default: SYM_BLANK};
      r_code   <= '{default: 4'd0};
    end else if (result_valid) begin
      r_err    <= error;
      r_sign   <= result[WIDTH-1];
      r_mag    <= result[WIDTH-1] ? -result : result;
      r_bcd    <= '0;
      r_bitcnt <= '0;
    end else begin
      unique case (r_state)
        CONVERT: begin
          r_bcd    <= w_bcd_nxt;
          r_mag    <= w_mag_nxt;
          r_bitcnt <= r_bitcnt + BW'(1);
          if (w_conv_done) begin
            r_kind <= w_kind;
            r_code <= w_code;
            r_nsym <= w_nsym;
            r_idx  <= '0;
            r_cnt  <= CW'(DIGIT_HOLD - 1);
          end
        end
        SHOW: begin
          if (w_cnt_zero)
            r_cnt <= w_last ? CW'(LGAP - 1) : CW'(GAP - 1);
          else
            r_cnt <= r_cnt - CW'(1);
        end
        BLANK: begin
          if (w_cnt_zero) begin
            r_idx <= w_last ? '0 : r_idx + IW'(1);
            r_cnt <= CW'(DIGIT_HOLD - 1);
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  calc_seg7_encode u_enc (
    .i_code (r_code[r_idx]),
    .i_kind (r_kind[r_idx]),
    .o_seg  (w_seg)
  );

  always_comb begin
    segments = SEG_BLANK;
    dp       = 1'b0;
    busy     = 1'b0;
    unique case (r_state)
      CONVERT: busy = 1'b1;
      SHOW: begin
        segments = w_seg;
        dp       = w_last;
      end
      default: ;
    endcase
  end

  a_bcd_digit: assert property (@(posedge clk) disable iff (rst)
    (r_state == SHOW && r_kind[r_idx] == SYM_DIGIT)
      |-> (r_code[r_idx] <= 4'd9));

endmodule

// File: tb/tb_calc_result_display.sv
// Directed bench for calc_result_display with short hold/gap timing.
// Drive 1 time unit after posedge, sample on negedge.
module tb_calc_result_display;

  localparam int DH = 4;
  localparam int GP = 2;
  localparam int EG = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       result_valid;
  logic [7:0] result;
  logic       error;
  logic [6:0] segments;
  logic       dp;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] g_sym [4];
  int         g_n;

  always #5 clk = ~clk;

  calc_result_display #(
    .WIDTH(8), .NDIG(3), .DIGIT_HOLD(DH), .GAP(GP), .END_GAP(EG)
  ) dut (
    .clk(clk), .rst(rst), .result_valid(result_valid),
    .result(result), .error(error),
    .segments(segments), .dp(dp), .busy(busy)
  );

  // Expected segments/dp at cycle c of the repeating playout.
  function automatic void exp_at(input int c,
                                 output logic [6:0] s,
                                 output logic d);
    int p;
    int blank;
    p = c % (g_n * (DH + GP) + EG);
    s = 7'd0;
    d = 1'b0;
    for (int k = 0; k < g_n; k++) begin
      blank = GP + ((k == g_n - 1) ? EG : 0);
      if (p < DH) begin
        s = g_sym[k];
        d = (k == g_n - 1);
        return;
      end
      p -= DH;
      if (p < blank) return;
      p -= blank;
    end
  endfunction

  task automatic strobe(input logic [7:0] r, input logic e);
    @(posedge clk); #1;
    result_valid = 1'b1;
    result = r;
    error = e;
    @(posedge clk); #1;
    result_valid = 1'b0;
    error = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if (segments !== 7'd0 || dp !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: seg=%b dp=%b busy=%b want 0/0/0",
               segments, dp, busy);
    end
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (segments !== 7'd0 || dp !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_idle c%0d: seg=%b dp=%b busy=%b want 0",
                 c, segments, dp, busy);
      end
    end
  endtask

  task automatic test_positive;
    logic [6:0] es;
    logic       ed;
    g_sym[0] = 7'b0000110; g_sym[1] = 7'b1011011;
    g_sym[2] = 7'b1001111; g_n = 3;
    strobe(8'd123, 1'b0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1 || segments !== 7'd0) begin
        n_bad++;
        $display("FAIL pos_busy c%0d: busy=%b seg=%b want 1/0",
                 c, busy, segments);
      end
    end
    for (int c = 0; c < 42; c++) begin
      exp_at(c, es, ed);
      @(negedge clk);
      n_cmp++;
      if (segments !== es || dp !== ed || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL pos_play c%0d: seg=%b dp=%b busy=%b want %b/%b/0",
                 c, segments, dp, busy, es, ed);
      end
    end
  endtask

  task automatic test_negative;
    logic [6:0] es;
    logic       ed;
    g_sym[0] = 7'b1000000; g_sym[1] = 7'b0000110;
    g_sym[2] = 7'b1011011; g_sym[3] = 7'b1111111; g_n = 4;
    strobe(8'h80, 1'b0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1 || segments !== 7'd0) begin
        n_bad++;
        $display("FAIL neg_busy c%0d: busy=%b seg=%b want 1/0",
                 c, busy, segments);
      end
    end
    for (int c = 0; c < 30; c++) begin
      exp_at(c, es, ed);
      @(negedge clk);
      n_cmp++;
      if (segments !== es || dp !== ed || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL neg_play c%0d: seg=%b dp=%b busy=%b want %b/%b/0",
                 c, segments, dp, busy, es, ed);
      end
    end
  endtask

  task automatic test_single;
    logic [7:0] vals [2];
    logic [6:0] segs [2];
    logic [6:0] es;
    logic       ed;
    vals[0] = 8'd0; segs[0] = 7'b0111111;
    vals[1] = 8'd7; segs[1] = 7'b0000111;
    for (int v = 0; v < 2; v++) begin
      g_sym[0] = segs[v]; g_n = 1;
      strobe(vals[v], 1'b0);
      repeat (8) @(negedge clk);
      for (int c = 0; c < 18; c++) begin
        exp_at(c, es, ed);
        @(negedge clk);
        n_cmp++;
        if (segments !== es || dp !== ed) begin
          n_bad++;
          $display("FAIL single_%0d c%0d: seg=%b dp=%b want %b/%b",
                   vals[v], c, segments, dp, es, ed);
        end
      end
    end
  endtask

  task automatic test_error;
    logic [6:0] es;
    logic       ed;
    g_sym[0] = 7'b1111001; g_n = 1;
    strobe(8'd55, 1'b1);
    repeat (8) @(negedge clk);
    for (int c = 0; c < 18; c++) begin
      exp_at(c, es, ed);
      @(negedge clk);
      n_cmp++;
      if (segments !== es || dp !== ed) begin
        n_bad++;
        $display("FAIL error_E c%0d: seg=%b dp=%b want %b/%b",
                 c, segments, dp, es, ed);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [6:0] es;
    logic       ed;
    strobe(8'd123, 1'b0);
    repeat (8 + 2) @(negedge clk);
    n_cmp++;
    if (segments !== 7'b0000110) begin
      n_bad++;
      $display("FAIL b2b_pre: seg=%b want 0000110", segments);
    end
    g_sym[0] = 7'b1101111; g_n = 1;
    strobe(8'd9, 1'b0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1 || segments !== 7'd0 || dp !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_busy c%0d: busy=%b seg=%b dp=%b want 1/0/0",
                 c, busy, segments, dp);
      end
    end
    for (int c = 0; c < 9; c++) begin
      exp_at(c, es, ed);
      @(negedge clk);
      n_cmp++;
      if (segments !== es || dp !== ed) begin
        n_bad++;
        $display("FAIL b2b_play c%0d: seg=%b dp=%b want %b/%b",
                 c, segments, dp, es, ed);
      end
    end
  endtask

  // Second strobe lands on the final CONVERT edge of the first.
  task automatic test_final_cycle_restart;
    logic [6:0] es;
    logic       ed;
    strobe(8'd123, 1'b0);
    repeat (6) @(posedge clk);
    g_sym[0] = 7'b1100110; g_sym[1] = 7'b1101101; g_n = 2;
    strobe(8'd45, 1'b0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1 || segments !== 7'd0) begin
        n_bad++;
        $display("FAIL last_busy c%0d: busy=%b seg=%b want 1/0",
                 c, busy, segments);
      end
    end
    for (int c = 0; c < 15; c++) begin
      exp_at(c, es, ed);
      @(negedge clk);
      n_cmp++;
      if (segments !== es || dp !== ed || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL last_play c%0d: seg=%b dp=%b busy=%b want %b/%b/0",
                 c, segments, dp, busy, es, ed);
      end
    end
  endtask

  task automatic test_reset_mid;
    strobe(8'd123, 1'b0);
    repeat (8 + 1) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (segments !== 7'b0000110) begin
      n_bad++;
      $display("FAIL rstmid_pre: seg=%b want 0000110", segments);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_cmp++;
      if (segments !== 7'd0 || dp !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL rstmid c%0d: seg=%b dp=%b busy=%b want 0",
                 c, segments, dp, busy);
      end
    end
  endtask

  task automatic test_reset_vs_valid;
    @(posedge clk); #1;
    rst = 1'b1;
    result_valid = 1'b1;
    result = 8'd50;
    @(posedge clk); #1;
    rst = 1'b0;
    result_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_cmp++;
      if (segments !== 7'd0 || dp !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_wins c%0d: seg=%b dp=%b busy=%b want 0",
                 c, segments, dp, busy);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    result_valid = 1'b0;
    result = 8'd0;
    error = 1'b0;
    test_reset();
    test_positive();
    test_negative();
    test_single();
    test_error();
    test_back_to_back();
    test_final_cycle_restart();
    test_reset_mid();
    test_reset_vs_valid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
